fwft_out_stage: RTL and testbench

//  Read-side stage placed directly downstream of sc_fifo. It turns the FIFO's

---
 rtl/fwft_pkg.sv | 21 ++
 rtl/sc_fifo.sv | 78 +++++++
 rtl/fwft_out_stage.sv | 109 ++++++++++
 tb/tb_fwft_out_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwft_pkg.sv
// rtl/fwft_pkg.sv - shared types and constants for the FWFT output stage
//
// Purpose: occupancy encoding of the two-slot output buffer and its depth,
//          plus a helper turning the occupancy state into a word count.
// Ports:   none (package).
package fwft_pkg;

  typedef enum logic [1:0] {
    OCC_0 = 2'd0,
    OCC_1 = 2'd1,
    OCC_2 = 2'd2
  } occ_e;

  localparam int BUF_DEPTH = 2;

  // The encoding is chosen so that the state value is the word count.
  function automatic logic [1:0] occ_words(input occ_e occ);
    return occ;
  endfunction

endpackage

// File: rtl/sc_fifo.sv
// rtl/sc_fifo.sv - single-clock FIFO with registered read data and flags
//
// Purpose: DEPTH-entry queue (DEPTH must be a power of two). A pop request
//          on rd_en presents the word on dout one cycle later; empty and
//          full are registered.
// Ports:   clk, rst_n (async, active-low)
//          wr_en, din        push side (ignored while full)
//          rd_en, dout       pop side (ignored while empty)
//          empty, full       registered status flags
module sc_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_n;
  logic                  empty_q, full_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  wr_ok, rd_ok;

  assign wr_ok = wr_en && !full_q;
  assign rd_ok = rd_en && !empty_q;

  always_comb begin
    count_n = count_q;
    if (wr_ok && !rd_ok) begin
      count_n = count_q + (AW+1)'(1);
    end else if (rd_ok && !wr_ok) begin
      count_n = count_q - (AW+1)'(1);
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        dout_q   <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_n;
      empty_q <= (count_n == '0);
      full_q  <= (count_n == (AW+1)'(DEPTH));
    end
  end

  assign dout  = dout_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/fwft_out_stage.sv
// rtl/fwft_out_stage.sv - first-word-fall-through valid/ready stage after sc_fifo
//
// Purpose: converts the FIFO's registered-read interface into a valid/ready
//          stream using an out slot plus a skid slot and one read in flight,
//          sustaining one word per clock under continuous m_ready.
// Ports:   clk, rst_n (async, active-low)
//          fifo_empty, fifo_dout   from sc_fifo
//          fifo_rd_en              pop request to sc_fifo (combinational)
//          m_data, m_valid, m_ready  output stream
//          m_level                 occ + inflight, only with FWFT_LEVEL_EN
// Config:  define FWFT_LEVEL_EN to add the m_level port.
module fwft_out_stage
  import fwft_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef FWFT_LEVEL_EN
  ,
  output logic [1:0]            m_level
`endif
);

  occ_e                  occ_q, occ_n;
  logic                  inflight_q;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] out_q, out_n;
  logic [DATA_WIDTH-1:0] skid_q, skid_n;
  logic                  pop;
  logic                  arrival;
  logic [2:0]            level_after_pop;

  assign pop     = m_valid_q && m_ready;
  assign arrival = inflight_q;

  // Words held plus word in flight, minus the one leaving this cycle. A new
  // read is only issued if the result still leaves a free slot, so the
  // buffer can never overflow and no backpressure path to the FIFO exists.
  assign level_after_pop = {1'b0, occ_words(occ_q)} + {2'b00, inflight_q}
                         - {2'b00, pop};

  // Gated by rst_n so no pop reaches the FIFO while reset is held.
  assign fifo_rd_en = rst_n && !fifo_empty && (level_after_pop < 3'(BUF_DEPTH));

  always_comb begin
    occ_n  = occ_q;
    out_n  = out_q;
    skid_n = skid_q;
    case (occ_q)
      OCC_0: begin
        if (arrival) begin
          out_n = fifo_dout;
          occ_n = OCC_1;
        end
      end
      OCC_1: begin
        if (arrival && pop) begin
          out_n = fifo_dout;
        end else if (arrival) begin
          skid_n = fifo_dout;
          occ_n  = OCC_2;
        end else if (pop) begin
          occ_n = OCC_0;
        end
      end
      OCC_2: begin
        // No arrival is possible here: the read credit was exhausted.
        if (pop) begin
          out_n = skid_q;
          occ_n = OCC_1;
        end
      end
      default: begin
        occ_n = OCC_0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= OCC_0;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      occ_q      <= occ_n;
      inflight_q <= fifo_rd_en;
      m_valid_q  <= (occ_n != OCC_0);
      out_q      <= out_n;
      skid_q     <= skid_n;
    end
  end

  assign m_data  = out_q;
  assign m_valid = m_valid_q;

`ifdef FWFT_LEVEL_EN
  assign m_level = occ_words(occ_q) + {1'b0, inflight_q};
`endif

endmodule

// File: tb/tb_fwft_out_stage.sv
// tb/tb_fwft_out_stage.sv - scoreboard bench for sc_fifo + fwft_out_stage
module tb_fwft_out_stage;
  import fwft_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          full;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
`ifdef FWFT_LEVEL_EN
  logic [1:0]    m_level;
`endif

  always #5 clk = ~clk;

  sc_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .din   (din),
    .rd_en (fifo_rd_en),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (full)
  );

  fwft_out_stage #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
`ifdef FWFT_LEVEL_EN
    ,
    .m_level    (m_level)
`endif
  );

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  int pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Words enter the reference queue when the FIFO accepts them; the stream
  // must reproduce that queue exactly.
  task automatic push_word(input logic [DW-1:0] d);
    int guard = 0;
    while (full && guard < 100) begin
      tick();
      guard++;
    end
    if (full) check("push_timeout", 32'(full), 32'd0);
    wr_en = 1'b1;
    din   = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  // Monitor: samples on the falling edge, between drive and capture.
  logic          hold_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      check("rd_en_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      if (hold_prev) begin
        check("valid_retracted", 32'(m_valid), 32'd1);
        check("data_changed_under_stall", 32'(m_data), 32'(data_prev));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none", m_data);
        end else begin
          check("sb_order", 32'(m_data), 32'(exp_q.pop_front()));
        end
        pops++;
        pop_cyc.push_back(cyc);
      end
      hold_prev = m_valid && !m_ready;
      data_prev = m_data;
    end
  end

  initial begin
    int p0;
    int sent;
    int guard;
    logic [DW-1:0] rnd;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
`ifdef FWFT_LEVEL_EN
    check("rst_level", 32'(m_level), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // 1: single word latency
    m_ready = 1'b1;
    push_word(8'hA5);
    check("s1_valid_c1", 32'(m_valid), 32'd0);
    tick();
    check("s1_valid_c2", 32'(m_valid), 32'd0);
    tick();
    check("s1_valid_c3", 32'(m_valid), 32'd1);
    check("s1_data_c3", 32'(m_data), 32'hA5);
    tick();
    check("s1_valid_c4", 32'(m_valid), 32'd0);
    repeat (2) tick();

    // 2: back-to-back throughput
    pop_cyc.delete();
    p0 = pops;
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    repeat (6) tick();
    check("s2_count", 32'(pops - p0), 32'd4);
    if (pop_cyc.size() == 4) begin
      for (int i = 0; i < 3; i++)
        check("s2_no_bubble", 32'(pop_cyc[i+1] - pop_cyc[i]), 32'd1);
    end

    // 3: stall with full buffer, then release
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h10 + DW'(i));
    repeat (10) tick();
    check("s3_valid", 32'(m_valid), 32'd1);
    check("s3_head", 32'(m_data), 32'h10);
    check("s3_occ", 32'(dut.occ_q), 32'(OCC_2));
    check("s3_rd_en_low", 32'(fifo_rd_en), 32'd0);
`ifdef FWFT_LEVEL_EN
    check("s3_level", 32'(m_level), 32'd2);
`endif
    m_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    check("s3_drained", 32'(exp_q.size()), 32'd0);

    // 4: random traffic and backpressure
    p0 = pops;
    sent = 0;
    guard = 0;
    while ((sent < 1000 || exp_q.size() != 0) && guard < 20000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 1000 && !full && $urandom_range(0, 3) != 0) begin
        rnd = DW'($urandom);
        wr_en = 1'b1;
        din = rnd;
        exp_q.push_back(rnd);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      guard++;
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    tick();
    check("s4_drained", 32'(exp_q.size()), 32'd0);
    check("s4_pops", 32'(pops - p0), 32'd1000);

    // 5: asynchronous reset with buffered and queued words
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h20 + DW'(i));
    repeat (3) tick();
    check("s5_pre_valid", 32'(m_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("s5_async_valid", 32'(m_valid), 32'd0);
    check("s5_async_data", 32'(m_data), 32'd0);
    check("s5_async_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    m_ready = 1'b1;
    p0 = pops;
    push_word(8'h77);
    repeat (8) tick();
    check("s5_single_word", 32'(pops - p0), 32'd1);
    check("s5_idle_after", 32'(m_valid), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
